fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word addresses to a one-cycle-latency instruction
// memory, presents fetched words to decode, and handles stall, redirect and faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] i_addr,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic [1:0]  state_dbg
);

  // Decode handshake: a word moves to decode on a cycle where id_valid && id_ready.
  // id_valid never depends on id_ready; once raised, id_pc/id_instr hold until the
  // transfer, unless a redirect discards the word.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;

  // One bit wider than an address so IMEM_WORDS*4 = 2^32 cannot overflow.
  localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] rsp_pc_q;
  logic        rsp_valid_q;

  logic        advance;
  logic        transfer;
  logic        issue;
  logic        issue_ok;
  logic [31:0] issue_addr;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIMIT);
  endfunction

  assign id_valid  = rsp_valid_q && (state == RUN) && !redirect;
  assign id_pc     = rsp_pc_q;
  assign id_instr  = instruction;
  assign transfer  = id_valid && id_ready;
  assign advance   = !rsp_valid_q || id_ready;
  assign state_dbg = state;

  always_comb begin
    issue      = 1'b0;
    issue_addr = pc_q;
    case (state)
      IDLE: issue = fetch_en;
      RUN: begin
        if (redirect) begin
          issue      = 1'b1;
          issue_addr = redirect_pc;
        end else if (advance) begin
          issue = 1'b1;
        end else begin
          // Stall: re-read the held word so instruction stays stable.
          issue_addr = rsp_pc_q;
        end
      end
      FAULT: begin
        if (redirect) begin
          issue      = 1'b1;
          issue_addr = redirect_pc;
        end
      end
      default: issue = 1'b0;
    endcase
  end

  assign i_addr   = issue_addr;
  assign issue_ok = addr_legal(issue_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rsp_valid_q <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      if (issue) begin
        if (issue_ok) begin
          rsp_pc_q    <= issue_addr;
          rsp_valid_q <= 1'b1;
          pc_q        <= issue_addr + 32'd4;
          state       <= RUN;
        end else begin
          // Illegal fetch: pc_q keeps its value, the word read is never presented.
          fetch_fault <= 1'b1;
          rsp_valid_q <= 1'b0;
          state       <= FAULT;
        end
      end
      if (transfer) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a cycle-level reference model of the fetch
// rules with a per-cycle compare, plus hand-computed literal checks.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] i_addr;
  logic [31:0] instruction;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .i_addr(i_addr),
    .instruction(instruction), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory (mem[i] = i) ----------------
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = i;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:10] == 22'd0) return mem[a[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) instruction <= mem_rd(i_addr);

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_mode: 0 waiting for fetch_en, 1 streaming, 2 faulted
  int          m_mode = 0;
  logic [31:0] m_next = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic        m_has = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_count = 32'h0;

  function automatic logic legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic logic exp_valid();
    return m_has && m_mode == 1 && !redirect;
  endfunction

  function automatic logic [31:0] exp_addr();
    if (m_mode != 0 && redirect) return redirect_pc;
    if (m_mode == 1 && m_has && !id_ready) return m_pc;
    return m_next;
  endfunction

  task automatic m_issue(input logic [31:0] a);
    if (legal(a)) begin
      m_pc = a; m_has = 1'b1; m_next = a + 32'd4; m_mode = 1;
    end else begin
      m_fault = 1'b1; m_has = 1'b0; m_mode = 2;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_next = 32'h0; m_pc = 32'h0; m_has = 1'b0;
      m_fault = 1'b0; m_count = 32'h0;
    end else begin
      if (exp_valid() && id_ready) m_count = m_count + 32'd1;
      if (m_mode == 0) begin
        if (fetch_en) m_issue(m_next);
      end else if (redirect) begin
        m_issue(redirect_pc);
      end else if (m_mode == 1 && (!m_has || id_ready)) begin
        m_issue(m_next);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
    end else begin
      chk("id_valid", {31'd0, id_valid}, {31'd0, exp_valid()});
      chk("i_addr", i_addr, exp_addr());
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      chk("fetch_count", fetch_count, m_count);
      if (exp_valid()) begin
        chk("id_pc", id_pc, m_pc);
        chk("id_instr", id_instr, mem_rd(m_pc));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int   last_pc;
  logic saw_fault;

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    cyc(2);
    #3;
    chk("lit_reset_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_reset_count", fetch_count, 32'd0);
    chk("lit_reset_fault", {31'd0, fetch_fault}, 32'd0);
    chk("lit_reset_addr", i_addr, 32'h0);

    rst_n = 1'b1;
    cyc(1);
    #3 chk("lit_idle_valid", {31'd0, id_valid}, 32'd0);
    fetch_en = 1'b1; id_ready = 1'b1;
    cyc(1);
    #3 chk("lit_first_pc", id_pc, 32'h0);
    chk("lit_first_instr", id_instr, 32'd0);
    chk("lit_first_valid", {31'd0, id_valid}, 32'd1);
    cyc(1);
    #3 chk("lit_second_pc", id_pc, 32'h4);

    // Stall three cycles with word 8 presented.
    cyc(1);
    id_ready = 1'b0;
    #3 chk("lit_stall_pc", id_pc, 32'h8);
    chk("lit_stall_addr", i_addr, 32'h8);
    cyc(2);
    #3 chk("lit_stall3_pc", id_pc, 32'h8);
    chk("lit_stall3_instr", id_instr, 32'd2);
    chk("lit_stall3_count", fetch_count, 32'd2);
    cyc(1);
    id_ready = 1'b1;
    cyc(1);
    #3 chk("lit_resume_pc", id_pc, 32'hC);
    chk("lit_resume_count", fetch_count, 32'd3);

    // Redirect with id_ready low still discards the held word.
    cyc(1);
    redirect = 1'b1; redirect_pc = 32'h40; id_ready = 1'b0;
    #3 chk("lit_redir_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_redir_addr", i_addr, 32'h40);
    cyc(1);
    redirect = 1'b0; id_ready = 1'b1;
    #3 chk("lit_redir_pc", id_pc, 32'h40);
    chk("lit_redir_instr", id_instr, 32'd16);
    chk("lit_redir_count", fetch_count, 32'd4);
    cyc(1);
    #3 chk("lit_redir_next", id_pc, 32'h44);

    for (int i = 0; i < 6; i++) begin
      cyc(1);
      id_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
    end

    // Misaligned redirect faults; a legal one recovers, flag stays set.
    cyc(1);
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
    #3 chk("lit_bad_addr", i_addr, 32'h42);
    cyc(1);
    redirect = 1'b0;
    #3 chk("lit_fault_flag", {31'd0, fetch_fault}, 32'd1);
    chk("lit_fault_valid", {31'd0, id_valid}, 32'd0);
    cyc(3);
    #3 chk("lit_fault_hold", {31'd0, id_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h10;
    cyc(1);
    redirect = 1'b0;
    #3 chk("lit_recover_pc", id_pc, 32'h10);
    chk("lit_recover_instr", id_instr, 32'd4);
    chk("lit_recover_fault", {31'd0, fetch_fault}, 32'd1);
    cyc(3);

    // Mid-stream reset, then run off the end of memory.
    rst_n = 1'b0;
    #3 chk("lit_midrst_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_midrst_count", fetch_count, 32'd0);
    chk("lit_midrst_fault", {31'd0, fetch_fault}, 32'd0);
    cyc(1);
    rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
    cyc(1);
    #3 chk("lit_restart_pc", id_pc, 32'h0);
    last_pc = -1;
    saw_fault = 1'b0;
    for (int i = 0; i < 300 && !saw_fault; i++) begin
      cyc(1);
      #3;
      if (fetch_fault) saw_fault = 1'b1;
      else if (id_valid && id_ready) last_pc = int'(id_pc);
    end
    chk("lit_end_fault_seen", {31'd0, saw_fault}, 32'd1);
    chk("lit_end_last_pc", 32'(last_pc), 32'h3FC);
    chk("lit_end_count", fetch_count, 32'd256);
    chk("lit_end_valid", {31'd0, id_valid}, 32'd0);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
